// File: rtl/skeeball_pkg.sv
// Shared constants for the skeeball score keeper: hole sensor indices,
// per-hole BCD increments and the game state encoding.
package skeeball_pkg;

  localparam int HOLE_W      = 7;
  localparam int HOLE_100    = 6;
  localparam int HOLE_50     = 5;
  localparam int HOLE_40     = 4;
  localparam int HOLE_30     = 3;
  localparam int HOLE_20     = 2;
  localparam int HOLE_10     = 1;
  localparam int HOLE_GUTTER = 0;

  // Two-digit BCD increments in score units (one unit = 10 displayed points).
  localparam logic [7:0] INC_100 = 8'h10;
  localparam logic [7:0] INC_50  = 8'h05;
  localparam logic [7:0] INC_40  = 8'h04;
  localparam logic [7:0] INC_30  = 8'h03;
  localparam logic [7:0] INC_20  = 8'h02;
  localparam logic [7:0] INC_10  = 8'h01;

  typedef enum logic [1:0] {IDLE, PLAY, FINISH, DONE} state_t;

  // Highest-value rising hole wins; a gutter ball (or nothing) adds zero.
  function automatic logic [7:0] hole_increment(input logic [HOLE_W-1:0] rise);
    if      (rise[HOLE_100]) return INC_100;
    else if (rise[HOLE_50])  return INC_50;
    else if (rise[HOLE_40])  return INC_40;
    else if (rise[HOLE_30])  return INC_30;
    else if (rise[HOLE_20])  return INC_20;
    else if (rise[HOLE_10])  return INC_10;
    else                     return 8'h00;
  endfunction

endpackage

// File: rtl/skeeball_score_keeper_bcd_digit_add.sv
// One decimal digit of the ripple BCD adder: digit = (a + b + carry_in) mod 10.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [4:0] raw;
  logic [4:0] adj;

  // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};
    adj = raw - 5'd10;
    if (raw > 5'd9) begin
      digit     = adj[3:0];
      carry_out = 1'b1;
    end else begin
      digit     = raw[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/skeeball_score_keeper.sv
// Skeeball lane score keeper: synchronises hole sensors, scores one ball per
// rising sensor event in BCD, runs the game FSM and keeps the high score.
module skeeball_score_keeper
  import skeeball_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BALLS       = 9,
  parameter int SATURATE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       playstate,
  input  logic [HOLE_W-1:0]          hole,
  output logic [4*DIGITS-1:0]        score,
  output logic [4*DIGITS-1:0]        high_score,
  output logic [$clog2(BALLS+1)-1:0] balls_left,
  output logic                       ball_pulse,
  output logic                       game_over,
  output logic                       new_high,
  output logic                       overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int BW = $clog2(BALLS + 1);
  localparam logic [BW-1:0] BALLS_INIT = BW'(BALLS);
  localparam logic [BW-1:0] ONE        = BW'(1);
  localparam logic [SW-1:0] ALL_NINES  = {DIGITS{4'h9}};

  logic [HOLE_W-1:0] sync_ff [SYNC_STAGES];
  logic [HOLE_W-1:0] sync_q;
  logic [HOLE_W-1:0] rise;
  logic              playstate_q;
  logic              start;
  logic              stop;
  logic              ball_event;
  logic [7:0]        inc;
  logic [SW-1:0]     addend;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     next_score;
  logic [DIGITS:0]   carry;
  state_t            state;

  // The edge register runs in every state so a sensor already high at game start never scores.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      sync_q      <= '0;
      playstate_q <= 1'b0;
    end else begin
      sync_ff[0] <= hole;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      sync_q      <= sync_ff[SYNC_STAGES-1];
      playstate_q <= playstate;
    end
  end

  assign rise       = sync_ff[SYNC_STAGES-1] & ~sync_q;
  assign start      = playstate & ~playstate_q;
  assign stop       = ~playstate & playstate_q;
  assign ball_event = (state == PLAY) && (|rise);
  assign inc        = hole_increment(rise);
  assign addend     = SW'(inc);
  assign carry[0]   = 1'b0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_add u_digit (
      .a         (score[4*g +: 4]),
      .b         (addend[4*g +: 4]),
      .carry_in  (carry[g]),
      .digit     (sum[4*g +: 4]),
      .carry_out (carry[g+1])
    );
  end

  assign next_score = (carry[DIGITS] && (SATURATE != 0)) ? ALL_NINES : sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      score      <= '0;
      high_score <= '0;
      balls_left <= '0;
      ball_pulse <= 1'b0;
      game_over  <= 1'b0;
      new_high   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ball_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= PLAY;
            score      <= '0;
            balls_left <= BALLS_INIT;
            game_over  <= 1'b0;
            new_high   <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        PLAY: begin
          if (ball_event) begin
            score      <= next_score;
            balls_left <= balls_left - ONE;
            ball_pulse <= 1'b1;
            if (carry[DIGITS]) overflow <= 1'b1;
          end
          // A ball arriving with the playstate fall is still scored before finishing.
          if ((ball_event && (balls_left == ONE)) || stop) begin
            state     <= FINISH;
            game_over <= 1'b1;
          end
        end
        FINISH: begin
          // BCD digits order like binary, so a plain unsigned compare is exact.
          if (score > high_score) begin
            high_score <= score;
            new_high   <= 1'b1;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skeeball_score_keeper.sv
// Self-checking bench for skeeball_score_keeper: scoreboarded ball events on a
// 4-digit lane plus carry, overflow and asynchronous-reset scenarios.
module tb_skeeball_score_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        playstate;
  logic [6:0]  hole_main, hole_long, hole_small;

  logic [15:0] main_score, main_high;
  logic [3:0]  main_balls;
  logic        main_pulse, main_gover, main_nhigh, main_ovf;

  logic [15:0] long_score, long_high;
  logic [4:0]  long_balls;
  logic        long_pulse, long_gover, long_nhigh, long_ovf;

  logic [7:0]  sat_score, sat_high;
  logic [4:0]  sat_balls;
  logic        sat_pulse, sat_gover, sat_nhigh, sat_ovf;

  logic [7:0]  wrap_score, wrap_high;
  logic [4:0]  wrap_balls;
  logic        wrap_pulse, wrap_gover, wrap_nhigh, wrap_ovf;

  typedef struct {
    logic [15:0] score;
    int          balls;
    logic        gover;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   passes    = 0;
  int   pulse_cnt = 0;
  int   m_units;
  int   m_balls;

  always #5 clk = ~clk;

  skeeball_score_keeper #(.DIGITS(4), .BALLS(9), .SATURATE(1), .SYNC_STAGES(2)) u_main (
    .clk(clk), .rst_n(rst_n), .playstate(playstate), .hole(hole_main),
    .score(main_score), .high_score(main_high), .balls_left(main_balls),
    .ball_pulse(main_pulse), .game_over(main_gover), .new_high(main_nhigh), .overflow(main_ovf));

  skeeball_score_keeper #(.DIGITS(4), .BALLS(20), .SATURATE(1), .SYNC_STAGES(2)) u_long (
    .clk(clk), .rst_n(rst_n), .playstate(playstate), .hole(hole_long),
    .score(long_score), .high_score(long_high), .balls_left(long_balls),
    .ball_pulse(long_pulse), .game_over(long_gover), .new_high(long_nhigh), .overflow(long_ovf));

  skeeball_score_keeper #(.DIGITS(2), .BALLS(20), .SATURATE(1), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .playstate(playstate), .hole(hole_small),
    .score(sat_score), .high_score(sat_high), .balls_left(sat_balls),
    .ball_pulse(sat_pulse), .game_over(sat_gover), .new_high(sat_nhigh), .overflow(sat_ovf));

  skeeball_score_keeper #(.DIGITS(2), .BALLS(20), .SATURATE(0), .SYNC_STAGES(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .playstate(playstate), .hole(hole_small),
    .score(wrap_score), .high_score(wrap_high), .balls_left(wrap_balls),
    .ball_pulse(wrap_pulse), .game_over(wrap_gover), .new_high(wrap_nhigh), .overflow(wrap_ovf));

  function automatic logic [15:0] bcd16(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int inc_of(input int idx);
    case (idx)
      6: return 10;
      5: return 5;
      4: return 4;
      3: return 3;
      2: return 2;
      1: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [6:0] mask);
    exp_t e;
    int   inc;
    bit   found;
    inc   = 0;
    found = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i] && !found) begin
        inc   = inc_of(i);
        found = 1'b1;
      end
    end
    m_units += inc;
    m_balls--;
    e.score = bcd16(m_units);
    e.balls = m_balls;
    e.gover = (m_balls == 0);
    sb_q.push_back(e);
  endtask

  // which: 0 = main lane (scoreboarded), 1 = long lane, 2 = two-digit lanes
  task automatic hit(input logic [6:0] mask, input int hold, input int which);
    if (which == 0) push_model(mask);
    case (which)
      0:       hole_main  = mask;
      1:       hole_long  = mask;
      default: hole_small = mask;
    endcase
    repeat (hold) tick();
    hole_main  = '0;
    hole_long  = '0;
    hole_small = '0;
    repeat (5) tick();
  endtask

  task automatic start_game();
    playstate = 1'b1;
    repeat (2) tick();
    m_units = 0;
    m_balls = 9;
  endtask

  task automatic end_game();
    playstate = 1'b0;
    repeat (3) tick();
  endtask

  // Scoreboard: each main-lane ball_pulse pops the expected result.
  always @(negedge clk) begin
    if (rst_n && main_pulse) begin
      exp_t e;
      pulse_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got pulse with score=%h, required no pulse", main_score);
      end else begin
        e = sb_q.pop_front();
        if (main_score !== e.score || main_balls !== 4'(e.balls) || main_gover !== e.gover)
          $display("FAIL ball_event: got score=%h balls=%0d game_over=%b, required score=%h balls=%0d game_over=%b",
                   main_score, main_balls, main_gover, e.score, e.balls, e.gover);
        else passes++;
      end
    end
  end

  task automatic test_reset();
    checks++; if (main_score !== 16'h0) $display("FAIL reset_score: got %h required 0000", main_score); else passes++;
    checks++; if (main_high !== 16'h0) $display("FAIL reset_high: got %h required 0000", main_high); else passes++;
    checks++; if (main_balls !== 4'd0) $display("FAIL reset_balls: got %0d required 0", main_balls); else passes++;
    checks++; if (main_pulse !== 1'b0) $display("FAIL reset_pulse: got %b required 0", main_pulse); else passes++;
    checks++; if (main_gover !== 1'b0) $display("FAIL reset_game_over: got %b required 0", main_gover); else passes++;
    checks++; if (main_nhigh !== 1'b0) $display("FAIL reset_new_high: got %b required 0", main_nhigh); else passes++;
    checks++; if (main_ovf !== 1'b0) $display("FAIL reset_overflow: got %b required 0", main_ovf); else passes++;
  endtask

  task automatic test_idle_ignore();
    int p0;
    p0 = pulse_cnt;
    hole_main = 7'b0000010;
    repeat (5) tick();
    start_game();
    repeat (4) tick();
    checks++; if (main_score !== 16'h0) $display("FAIL held_sensor_score: got %h required 0000", main_score); else passes++;
    checks++; if (main_balls !== 4'd9) $display("FAIL start_balls: got %0d required 9", main_balls); else passes++;
    checks++; if (pulse_cnt !== p0) $display("FAIL held_sensor_pulse: got %0d pulses required %0d", pulse_cnt, p0); else passes++;
    hole_main = '0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    int p0;
    p0 = pulse_cnt;
    hit(7'b0100000, 2, 0);
    hit(7'b0010000, 2, 0);
    hit(7'b0001000, 2, 0);
    checks++; if (pulse_cnt - p0 !== 3) $display("FAIL basic_pulses: got %0d required 3", pulse_cnt - p0); else passes++;
    checks++; if (main_score !== 16'h0012) $display("FAIL basic_score: got %h required 0012", main_score); else passes++;
    checks++; if (main_balls !== 4'd6) $display("FAIL basic_balls: got %0d required 6", main_balls); else passes++;
  endtask

  task automatic test_priority();
    int p0;
    p0 = pulse_cnt;
    hit(7'b1000100, 2, 0);
    checks++; if (pulse_cnt - p0 !== 1) $display("FAIL multi_pulses: got %0d required 1", pulse_cnt - p0); else passes++;
    checks++; if (main_score !== 16'h0022) $display("FAIL multi_score: got %h required 0022", main_score); else passes++;
    hit(7'b0001000, 5, 0);
    checks++; if (pulse_cnt - p0 !== 2) $display("FAIL held_pulses: got %0d required 2", pulse_cnt - p0); else passes++;
    checks++; if (main_score !== 16'h0025 || main_balls !== 4'd4)
      $display("FAIL held_score: got %h/%0d required 0025/4", main_score, main_balls); else passes++;
  endtask

  task automatic test_game_end();
    hit(7'b1000000, 2, 0);
    hit(7'b0100000, 2, 0);
    hit(7'b0001000, 2, 0);
    push_model(7'b0000100);
    hole_main = 7'b0000100;
    tick();
    hole_main = '0;
    repeat (2) tick();
    checks++; if (main_gover !== 1'b1 || main_pulse !== 1'b1)
      $display("FAIL last_ball: got game_over=%b pulse=%b required 1/1", main_gover, main_pulse); else passes++;
    checks++; if (main_high !== 16'h0) $display("FAIL high_before_finish: got %h required 0000", main_high); else passes++;
    tick();
    checks++; if (main_high !== 16'h0045) $display("FAIL high_game1: got %h required 0045", main_high); else passes++;
    checks++; if (main_nhigh !== 1'b1) $display("FAIL new_high_game1: got %b required 1", main_nhigh); else passes++;
    repeat (3) tick();
    end_game();
    start_game();
    checks++; if (main_nhigh !== 1'b0 || main_gover !== 1'b0 || main_score !== 16'h0)
      $display("FAIL game2_start: got new_high=%b game_over=%b score=%h required 0/0/0000", main_nhigh, main_gover, main_score); else passes++;
    hit(7'b1000000, 2, 0);
    hit(7'b1000000, 2, 0);
    hit(7'b1000000, 2, 0);
    end_game();
    checks++; if (main_score !== 16'h0030) $display("FAIL game2_score: got %h required 0030", main_score); else passes++;
    checks++; if (main_gover !== 1'b1) $display("FAIL game2_over: got %b required 1", main_gover); else passes++;
    checks++; if (main_high !== 16'h0045 || main_nhigh !== 1'b0)
      $display("FAIL game2_high: got %h/%b required 0045/0", main_high, main_nhigh); else passes++;
  endtask

  task automatic test_carry_overflow();
    start_game();
    for (int i = 0; i < 9; i++) hit(7'b1000000, 1, 1);
    hit(7'b0100000, 1, 1);
    hit(7'b0010000, 1, 1);
    checks++; if (long_score !== 16'h0099) $display("FAIL long_0099: got %h required 0099", long_score); else passes++;
    hit(7'b0000010, 1, 1);
    checks++; if (long_score !== 16'h0100) $display("FAIL two_digit_carry: got %h required 0100", long_score); else passes++;
    hit(7'b1000000, 1, 1);
    checks++; if (long_score !== 16'h0110 || long_balls !== 5'd7)
      $display("FAIL long_0110: got %h/%0d required 0110/7", long_score, long_balls); else passes++;
    for (int i = 0; i < 9; i++) hit(7'b1000000, 1, 2);
    hit(7'b0100000, 1, 2);
    checks++; if (sat_score !== 8'h95 || wrap_score !== 8'h95 || sat_ovf !== 1'b0 || wrap_ovf !== 1'b0)
      $display("FAIL small_95: got sat=%h/%b wrap=%h/%b required 95/0 95/0", sat_score, sat_ovf, wrap_score, wrap_ovf); else passes++;
    hit(7'b1000000, 1, 2);
    checks++; if (sat_score !== 8'h99 || sat_ovf !== 1'b1)
      $display("FAIL saturate: got %h/%b required 99/1", sat_score, sat_ovf); else passes++;
    checks++; if (wrap_score !== 8'h05 || wrap_ovf !== 1'b1)
      $display("FAIL wrap: got %h/%b required 05/1", wrap_score, wrap_ovf); else passes++;
    checks++; if (main_score !== 16'h0 || main_balls !== 4'd9)
      $display("FAIL main_untouched: got %h/%0d required 0000/9", main_score, main_balls); else passes++;
    end_game();
  endtask

  task automatic test_async_reset();
    start_game();
    hit(7'b0000100, 2, 0);
    checks++; if (main_high !== 16'h0045) $display("FAIL high_kept: got %h required 0045", main_high); else passes++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (main_score !== 16'h0 || main_high !== 16'h0)
      $display("FAIL async_score_high: got %h/%h required 0000/0000", main_score, main_high); else passes++;
    checks++; if (main_balls !== 4'd0 || main_gover !== 1'b0 || main_nhigh !== 1'b0 || main_ovf !== 1'b0 || main_pulse !== 1'b0)
      $display("FAIL async_flags: got balls=%0d go=%b nh=%b ovf=%b pulse=%b required all 0",
               main_balls, main_gover, main_nhigh, main_ovf, main_pulse); else passes++;
    checks++; if (long_score !== 16'h0 || long_high !== 16'h0 || sat_ovf !== 1'b0)
      $display("FAIL async_aux: got long=%h/%h sat_ovf=%b required 0000/0000/0", long_score, long_high, sat_ovf); else passes++;
    playstate = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    playstate  = 1'b0;
    hole_main  = '0;
    hole_long  = '0;
    hole_small = '0;
    m_units    = 0;
    m_balls    = 9;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_idle_ignore();
    test_basic();
    test_priority();
    test_game_end();
    test_carry_overflow();
    test_async_reset();
    checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
